// File: rtl/pipe_pass_pkg.sv
// Shared types and constants for the pipe-pass detector: FSM state encodings and column height.
package pipe_pass_pkg;

    localparam int ROWS = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        IN_PIPE = 2'd2,
        DEAD    = 2'd3
    } pp_state_t;

    function automatic logic col_hit(input logic [ROWS-1:0] bird, input logic [ROWS-1:0] pipe);
        return |(bird & pipe);
    endfunction

endpackage

// File: rtl/pipe_pass_detector_edge_detect.sv
// Rising-edge detect of the start button; combinational rise, 1 cycle after the edge (3 with START_SYNC_EN).
// START_SYNC_EN adds a two-flop synchronizer ahead of the detector; no backpressure.
module edge_detect (
    input  logic clk,
    input  logic RST,
    input  logic in,
    output logic rise
);

`ifdef START_SYNC_EN
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign rise = r_sync2 & ~r_prev;
`else
    logic r_prev;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= in;
        end
    end

    assign rise = in & ~r_prev;
`endif

endmodule

// File: rtl/pipe_pass_detector.sv
// Flappy-bird pipe-pass/collision FSM; Score pulses the cycle after a cleared pipe, crash is sticky.
// Game state advances only on tick; start path optionally synchronized via START_SYNC_EN.
module pipe_pass_detector
    import pipe_pass_pkg::*;
(
    input  logic            clk,
    input  logic            RST,
    input  logic            tick,
    input  logic            start,
    input  logic [ROWS-1:0] bird_row,
    input  logic [ROWS-1:0] pipe_col,
    output logic            Score,
    output logic            crash,
    output logic [1:0]      state
);

    pp_state_t r_state;
    pp_state_t w_state_nxt;
    logic      r_score;
    logic      r_crash;
    logic      w_score_nxt;
    logic      w_crash_nxt;
    logic      w_start_evt;
    logic      w_hit;
    logic      w_pipe;

    edge_detect u_start_edge (
        .clk  (clk),
        .RST  (RST),
        .in   (start),
        .rise (w_start_evt)
    );

    // Non-one-hot bird_row is deliberately ANDed as-is.
    assign w_hit  = col_hit(bird_row, pipe_col);
    assign w_pipe = |pipe_col;

    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = 1'b0;
        w_crash_nxt = r_crash;
        case (r_state)
            IDLE: begin
                if (w_start_evt) w_state_nxt = CLEAR;
            end
            CLEAR: begin
                if (tick) begin
                    if (w_hit) begin
                        w_state_nxt = DEAD;
                        w_crash_nxt = 1'b1;
                    end else if (w_pipe) begin
                        w_state_nxt = IN_PIPE;
                    end
                end
            end
            IN_PIPE: begin
                if (tick) begin
                    if (w_hit) begin
                        w_state_nxt = DEAD;
                        w_crash_nxt = 1'b1;
                    end else if (!w_pipe) begin
                        w_state_nxt = CLEAR;
                        w_score_nxt = 1'b1;
                    end
                end
            end
            DEAD: begin
                if (w_start_evt) begin
                    w_state_nxt = IDLE;
                    w_crash_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_crash_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_score <= 1'b0;
            r_crash <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_score <= w_score_nxt;
            r_crash <= w_crash_nxt;
        end
    end

    assign Score = r_score;
    assign crash = r_crash;
    assign state = r_state;

endmodule

// File: tb/tb_pipe_pass_detector.sv
// Directed bench for pipe_pass_detector; outputs sampled 1 time unit after each rising edge.
module tb_pipe_pass_detector;

`ifdef START_SYNC_EN
    localparam int START_LAT = 3;
`else
    localparam int START_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        RST;
    logic        tick;
    logic        start;
    logic [15:0] bird_row;
    logic [15:0] pipe_col;
    logic        Score;
    logic        crash;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    pipe_pass_detector dut (
        .clk      (clk),
        .RST      (RST),
        .tick     (tick),
        .start    (start),
        .bird_row (bird_row),
        .pipe_col (pipe_col),
        .Score    (Score),
        .crash    (crash),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input logic [15:0] br, input logic [15:0] pc);
        bird_row = br;
        pipe_col = pc;
        tick     = 1'b1;
        step();
        tick     = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b0;
        for (int i = 0; i < START_LAT; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < START_LAT; i++) step();
    endtask

    task automatic test_reset();
        RST = 1'b1; tick = 1'b0; start = 1'b0; bird_row = '0; pipe_col = '0;
        step(); step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (Score !== 1'b0) begin errors++; $display("FAIL reset_score: got %b expected 0", Score); end
        checks++; if (crash !== 1'b0) begin errors++; $display("FAIL reset_crash: got %b expected 0", crash); end
        RST = 1'b0;
        step();
        do_tick(16'hFFFF, 16'hFFFF);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_ignores_tick_state: got %0d expected 0", state); end
        checks++; if (crash !== 1'b0) begin errors++; $display("FAIL idle_ignores_tick_crash: got %b expected 0", crash); end
    endtask

    task automatic test_start();
        start = 1'b1;
        for (int i = 1; i < START_LAT; i++) begin
            step();
            checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_early: got %0d expected 0 at cycle %0d", state, i); end
        end
        step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_latency: got %0d expected 1", state); end
        for (int i = 0; i < 4; i++) step();
        start = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_held: got %0d expected 1", state); end
    endtask

    task automatic test_pass();
        do_tick(16'h0010, 16'hFF0F);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pass_enter_state: got %0d expected 2", state); end
        checks++; if (Score !== 1'b0) begin errors++; $display("FAIL pass_enter_score: got %b expected 0", Score); end
        do_tick(16'h0010, 16'h0000);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL pass_exit_state: got %0d expected 1", state); end
        checks++; if (Score !== 1'b1) begin errors++; $display("FAIL pass_score_pulse: got %b expected 1", Score); end
        step();
        checks++; if (Score !== 1'b0) begin errors++; $display("FAIL pass_score_width: got %b expected 0", Score); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL pass_hold_state: got %0d expected 1", state); end
    endtask

    task automatic test_back_to_back();
        int scount;
        scount = 0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 3; k++) begin
                do_tick(16'h0010, 16'hFF0F);
                scount += int'(Score);
                step();
                scount += int'(Score);
            end
            checks++; if (scount !== p) begin errors++; $display("FAIL b2b_no_score_in_pipe: got %0d expected %0d", scount, p); end
            do_tick(16'h0010, 16'h0000);
            scount += int'(Score);
            step();
            scount += int'(Score);
        end
        checks++; if (scount !== 3) begin errors++; $display("FAIL b2b_score_count: got %0d expected 3", scount); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL b2b_state: got %0d expected 1", state); end
    endtask

    task automatic test_stale();
        do_tick(16'h00F0, 16'h0F0F);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL stale_multibit_state: got %0d expected 2", state); end
        bird_row = 16'h0100;
        pipe_col = 16'hFF0F;
        step(); step(); step();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL stale_notick_state: got %0d expected 2", state); end
        checks++; if (crash !== 1'b0) begin errors++; $display("FAIL stale_notick_crash: got %b expected 0", crash); end
        do_tick(16'hFFFF, 16'h0000);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL stale_exit_state: got %0d expected 1", state); end
        checks++; if (Score !== 1'b1) begin errors++; $display("FAIL stale_exit_score: got %b expected 1", Score); end
        step();
        do_tick(16'h0000, 16'hFFFF);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL zero_bird_state: got %0d expected 2", state); end
        checks++; if (crash !== 1'b0) begin errors++; $display("FAIL zero_bird_crash: got %b expected 0", crash); end
    endtask

    task automatic test_crash();
        do_tick(16'h0100, 16'hFF0F);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL crash_state: got %0d expected 3", state); end
        checks++; if (crash !== 1'b1) begin errors++; $display("FAIL crash_flag: got %b expected 1", crash); end
        checks++; if (Score !== 1'b0) begin errors++; $display("FAIL crash_score: got %b expected 0", Score); end
        do_tick(16'h0010, 16'h0000);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL dead_tick_state: got %0d expected 3", state); end
        checks++; if (crash !== 1'b1) begin errors++; $display("FAIL dead_tick_crash: got %b expected 1", crash); end
        checks++; if (Score !== 1'b0) begin errors++; $display("FAIL dead_tick_score: got %b expected 0", Score); end
        start = 1'b1;
        for (int i = 0; i < START_LAT; i++) step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL restart_state: got %0d expected 0", state); end
        checks++; if (crash !== 1'b0) begin errors++; $display("FAIL restart_crash: got %b expected 0", crash); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL held_start_retrigger: got %0d expected 0", state); end
        press_start();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL second_start: got %0d expected 1", state); end
        do_tick(16'h0001, 16'h0001);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL clear_hit_state: got %0d expected 3", state); end
        checks++; if (crash !== 1'b1) begin errors++; $display("FAIL clear_hit_crash: got %b expected 1", crash); end
        press_start();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL clear_hit_restart: got %0d expected 0", state); end
    endtask

    task automatic test_mid_reset();
        press_start();
        do_tick(16'h0010, 16'hFF0F);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL midrst_setup: got %0d expected 2", state); end
        RST = 1'b1;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL midrst_async: got %0d expected 0", state); end
        #1;
        RST = 1'b0;
        do_tick(16'h0010, 16'h0000);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d expected 0", state); end
        checks++; if (Score !== 1'b0) begin errors++; $display("FAIL midrst_score: got %b expected 0", Score); end
        checks++; if (crash !== 1'b0) begin errors++; $display("FAIL midrst_crash: got %b expected 0", crash); end
        step();
        checks++; if (Score !== 1'b0) begin errors++; $display("FAIL midrst_late_score: got %b expected 0", Score); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pass();
        test_back_to_back();
        test_stale();
        test_crash();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
